uart_parity_engine: RTL
=======================

# uart_parity_engine

Parametrised, bit-serial parity unit for the UART TX/RX paths. It accumulates parity over a configurable-width frame as bits stream past. In generate mode it delivers the parity bit for the TX serializer. In check mode it compares the received parity bit and keeps a sticky error flag and a saturating error counter for the register file.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 1..16.
- ERR_CNT_WIDTH, 8: width of the saturating parity-error counter; minimum 1.
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- start  input  1  frame start strobe; latches the config inputs and clears the accumulator.
- par_en  input  1  parity enable; latched on `start`.
- par_type  input  1  parity type, 0 = even, 1 = odd; latched on `start`.
- chk_mode  input  1  mode, 0 = generate (TX), 1 = check (RX); latched on `start`.
- bit_valid  input  1  qualifies `bit_in`.
- bit_in  input  1  serial data bit, or the received parity bit while in PAR.
- err_clr  input  1  clears `err_sticky` and `err_cnt`.
- busy  output  1  high in DATA or PAR.
- par_bit  output  1  computed parity bit; registered, holds until the next frame completes.
- par_bit_vld  output  1  one-cycle pulse when `par_bit` is updated.
- frame_done  output  1  one-cycle pulse at the end of the frame.
- par_err  output  1  one-cycle pulse on a parity mismatch.
- err_sticky  output  1  set on any mismatch; held until `err_clr` or `RST`.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of mismatches.

## Operation
- **States:**
  - IDLE: wait for `start`.
  - DATA: accumulate data bits.
  - PAR: wait for the received parity bit.
- **Accumulator:**
  - `acc` is a 1-bit XOR of the accepted data bits.
  - `bcnt` counts accepted bits, 0..DATA_WIDTH-1.
- **Expected parity:**
  - par_en=1, even: `acc`.
  - par_en=1, odd: `~acc`.
  - par_en=0: 0.
- **Transitions:**
  - IDLE + `start` → DATA; acc=0, bcnt=0; config latched.
  - DATA + `bit_valid`: acc ^= bit_in and bcnt++.
  - DATA, on the bit with bcnt==DATA_WIDTH-1:
    - `par_bit` is loaded with the expected value.
    - If chk_mode=1 and par_en=1 → PAR.
    - Otherwise → IDLE, with `frame_done` pulsed.
  - PAR + `bit_valid`: compare `bit_in` with the latched expected value → IDLE and pulse `frame_done`.
  - On a mismatch in PAR: also pulse `par_err`, set `err_sticky`, and increment `err_cnt`.
- **Generate vs check:**
  - In generate mode `par_bit_vld` pulses at frame end.
  - In check mode `par_bit_vld` pulses when DATA completes, before PAR.
- **Restart and ignored input:**
  - `start` in DATA or PAR aborts the frame: acc/bcnt cleared, config relatched, state DATA, no done/err pulse.
  - `bit_valid` in IDLE is ignored.
  - `bit_valid` in the same cycle as `start` is ignored; the first data bit is accepted the cycle after `start` at the earliest.
- **Error counter and clear:**
  - `err_cnt` saturates at 2^ERR_CNT_WIDTH-1.
  - `err_clr` together with a new mismatch in the same cycle: the result is err_sticky=1 and err_cnt=1.
  - `err_clr` alone: err_sticky=0 and err_cnt=0.
- **Config stability:** `par_en`, `par_type` and `chk_mode` changing mid-frame have no effect; only the values latched on `start` are used.

## Timing
- **Reset:**
  - `RST` high at a clock edge forces state=IDLE, acc=0 and bcnt=0.
  - All outputs go to 0: busy, par_bit, par_bit_vld, frame_done, par_err, err_sticky, err_cnt.
  - Reset mid-frame discards the frame; no pulses are generated.
  - `RST` overrides `start`.
- **busy:** rises the cycle after `start`; falls the cycle after the last accepted bit.
- **Pulse latency:**
  - `par_bit_vld`, `frame_done` and `par_err` are registered.
  - They assert in the cycle after the accepting edge, for exactly one cycle.
- **Throughput:**
  - One bit per cycle maximum.
  - A new `start` is accepted in the same cycle that `frame_done` is high.
- **Minimum frame length:**
  - Generate: DATA_WIDTH accepted bits.
  - Check: DATA_WIDTH+1 accepted bits.

## Test plan
- Generate, DATA_WIDTH=8, par_type=0, bits of 0xA5 sent LSB first (4 ones) → par_bit=0, with `par_bit_vld` and `frame_done` pulsing together one cycle after bit 7. Repeat with par_type=1 → par_bit=1.
- Check, even parity, data 0x07 (3 ones) then received parity 0 → par_err pulse, err_sticky=1, err_cnt=1. Repeat with parity 1 → no error, err_cnt unchanged.
- par_en=0 with chk_mode=1, data 0xFF → par_bit=0; `frame_done` after bit 7; no PAR state and no error.
- Abort: `start`, 5 bits, `start` again, then 8 bits of 0x01 with odd parity → par_bit=0; only one `frame_done`. `RST` asserted mid-frame → all outputs 0 and busy=0 the next cycle.
- Saturation and clear, ERR_CNT_WIDTH=2: five mismatched frames → err_cnt stays at 3. `err_clr` in the same cycle as a mismatch → err_cnt=1, err_sticky=1. `err_clr` alone → both 0.
- Gapped bit_valid (random idle cycles), with DATA_WIDTH=1 and DATA_WIDTH=16 → parity matches a reference XOR model over 1000 random frames.

Source files
------------

// File: rtl/uart_parity_engine.sv
// uart_parity_engine: bit-serial parity generator/checker with sticky error flag and saturating error counter
module uart_parity_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     par_en,
    input  logic                     par_type,
    input  logic                     chk_mode,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     err_clr,
    output logic                     busy,
    output logic                     par_bit,
    output logic                     par_bit_vld,
    output logic                     frame_done,
    output logic                     par_err,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
    state_t                   r_state;
    logic                     r_acc;
    logic [BW-1:0]            r_bcnt;
    logic                     r_par_en;
    logic                     r_par_type;
    logic                     r_chk_mode;
    logic                     r_par_bit;
    logic                     r_par_bit_vld;
    logic                     r_frame_done;
    logic                     r_par_err;
    logic                     r_err_sticky;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic                     w_acc_nxt;
    logic                     w_exp;
    logic                     w_last;
    logic                     w_to_par;
    assign w_acc_nxt = r_acc ^ bit_in;
    // expected parity including the bit being accepted this cycle
    assign w_exp     = r_par_en & (w_acc_nxt ^ r_par_type);
    assign w_last    = r_bcnt == LAST;
    assign w_to_par  = r_chk_mode & r_par_en;
    // frame FSM, accumulator, pulses and error bookkeeping; start aborts any frame, reset overrides all
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_acc         <= 1'b0;
            r_bcnt        <= '0;
            r_par_en      <= 1'b0;
            r_par_type    <= 1'b0;
            r_chk_mode    <= 1'b0;
            r_par_bit     <= 1'b0;
            r_par_bit_vld <= 1'b0;
            r_frame_done  <= 1'b0;
            r_par_err     <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_par_bit_vld <= 1'b0;
            r_frame_done  <= 1'b0;
            r_par_err     <= 1'b0;
            if (err_clr) begin
                r_err_sticky <= 1'b0;
                r_err_cnt    <= '0;
            end
            if (start) begin
                r_state    <= DATA;
                r_acc      <= 1'b0;
                r_bcnt     <= '0;
                r_par_en   <= par_en;
                r_par_type <= par_type;
                r_chk_mode <= chk_mode;
            end else begin
                unique case (r_state)
                    DATA: if (bit_valid) begin
                        r_acc         <= w_acc_nxt;
                        r_bcnt        <= w_last ? '0 : r_bcnt + 1'b1;
                        r_state       <= !w_last ? DATA : w_to_par ? PAR : IDLE;
                        r_par_bit     <= w_last ? w_exp : r_par_bit;
                        r_par_bit_vld <= w_last;
                        r_frame_done  <= w_last & ~w_to_par;
                    end
                    PAR: if (bit_valid) begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                        if (bit_in != r_par_bit) begin
                            r_par_err    <= 1'b1;
                            r_err_sticky <= 1'b1;
                            r_err_cnt    <= err_clr ? ERR_CNT_WIDTH'(1) : (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign busy        = r_state != IDLE;
    assign par_bit     = r_par_bit;
    assign par_bit_vld = r_par_bit_vld;
    assign frame_done  = r_frame_done;
    assign par_err     = r_par_err;
    assign err_sticky  = r_err_sticky;
    assign err_cnt     = r_err_cnt;
endmodule
